// File: rtl/uart_pkg.sv
// Purpose: shared UART state encodings, default bit timing and 8N1 frame constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Encoding is shared with the receiver so both ends decode state dumps the same way.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_START   = 3'b001,
    ST_DATA    = 3'b010,
    ST_STOP    = 3'b011,
    ST_CLEANUP = 3'b100
  } uart_state_e;

  localparam int   DEFAULT_CLKS_PER_BIT = 1085;
  localparam int   DATA_BITS            = 8;
  localparam int   STOP_BITS            = 1;
  localparam logic IDLE_LEVEL           = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Purpose: synchronous byte FIFO with wrap-bit pointers and full/empty flags.
// Latency: a pushed entry is visible on o_dat the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_BITS,
  parameter int DEPTH  = 16
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_dat,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_dat,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_ok, pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_dat   = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; push and pop in the same cycle leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop_ok)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer registers; reset flushes the FIFO.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge i_Clock) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/uart_tx.sv
// Purpose: 8N1 UART transmitter; TX_FIFO_EN selects a byte FIFO, else a one-byte holding register.
// Latency: byte accepted at edge k drives the start bit from edge k+1 when idle; frames repeat every 10*CLKS_PER_BIT+2.
// Backpressure: o_Tx_Ready low when the buffer is full; bytes offered while not ready are dropped.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  // Reject configurations the bit counter and buffer indexing cannot represent.
  if (CLKS_PER_BIT < 2 || STOP_BITS != 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx: unsupported CLKS_PER_BIT/FIFO_DEPTH");
  end

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          serial_q, serial_d;
  logic          done_q, done_d;

  logic       buf_push, buf_pop, buf_empty;
  logic [7:0] buf_dat;

  // Ready comes from pre-edge state, so a push can never target a full buffer.
  assign buf_push = i_Tx_DV && o_Tx_Ready;

`ifdef TX_FIFO_EN
  logic buf_full;

  uart_tx_fifo #(
    .DATA_W(8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_push (buf_push),
    .i_dat  (i_Tx_Byte),
    .i_pop  (buf_pop),
    .o_dat  (buf_dat),
    .o_full (buf_full),
    .o_empty(buf_empty)
  );

  assign o_Tx_Ready = !buf_full;
`else
  logic       hold_vld_q, hold_vld_d;
  logic [7:0] hold_dat_q, hold_dat_d;

  // Holding register loads on accept and empties when the FSM takes the byte.
  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    if (buf_push) begin
      hold_vld_d = 1'b1;
      hold_dat_d = i_Tx_Byte;
    end else if (buf_pop) begin
      hold_vld_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
    end
  end

  assign buf_empty  = !hold_vld_q;
  assign buf_dat    = hold_dat_q;
  assign o_Tx_Ready = !hold_vld_q;
`endif

  // Frame sequencer: next state, counters and the registered line level.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    done_d   = 1'b0;
    buf_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        serial_d = IDLE_LEVEL;
        cnt_d    = '0;
        idx_d    = '0;
        if (!buf_empty) begin
          buf_pop  = 1'b1;
          shift_d  = buf_dat;
          serial_d = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          idx_d    = '0;
          serial_d = shift_q[0];
          state_d  = ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            serial_d = IDLE_LEVEL;
            state_d  = ST_STOP;
          end else begin
            idx_d    = idx_q + 3'd1;
            serial_d = shift_q[idx_d];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_CLEANUP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CLEANUP: begin
        serial_d = IDLE_LEVEL;
        state_d  = ST_IDLE;
      end
      default: begin
        serial_d = IDLE_LEVEL;
        cnt_d    = '0;
        idx_d    = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset forces the line idle at once and abandons any frame.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= IDLE_LEVEL;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = done_q;
  assign o_Tx_Active = (state_q == ST_START) || (state_q == ST_DATA) ||
                       (state_q == ST_STOP);

endmodule

// File: tb/tb_uart_tx.sv
// Purpose: self-checking bench for uart_tx at 8, 2 and 1085 clocks per bit.
// Latency: frames checked cycle-by-cycle against hand-computed 10-bit patterns.
// Backpressure: exercises dropped bytes while Ready is low in both buffer builds.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       dv8, dv2, dvl;
  logic [7:0] b8, b2, bl;
  logic       rdy8, ser8, act8, dn8;
  logic       rdy2, ser2, act2, dn2;
  logic       rdyl, serl, actl, dnl;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         inst;
    int         cpb;
    logic [7:0] dat;
    logic [9:0] frame;   // frame[0] = start bit, frame[9] = stop bit
  } vec_t;

  vec_t       vecs[5];
  logic       cap     [0:1405];
  logic       cap_rdy [0:1405];
  logic [7:0] rx_got  [4];
  int         rx_cnt;

  uart_tx #(.CLKS_PER_BIT(8), .FIFO_DEPTH(16)) u_dut8 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv8), .i_Tx_Byte(b8),
    .o_Tx_Ready(rdy8), .o_Tx_Serial(ser8), .o_Tx_Active(act8), .o_Tx_Done(dn8));

  uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(16)) u_dut2 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv2), .i_Tx_Byte(b2),
    .o_Tx_Ready(rdy2), .o_Tx_Serial(ser2), .o_Tx_Active(act2), .o_Tx_Done(dn2));

  uart_tx #(.CLKS_PER_BIT(1085), .FIFO_DEPTH(16)) u_dutl (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dvl), .i_Tx_Byte(bl),
    .o_Tx_Ready(rdyl), .o_Tx_Serial(serl), .o_Tx_Active(actl), .o_Tx_Done(dnl));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_wait(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait expired, expected event never occurred", name);
  endtask

  function automatic logic ser_of(input int s);
    case (s)
      0:       return ser8;
      1:       return ser2;
      default: return serl;
    endcase
  endfunction

  function automatic logic act_of(input int s);
    case (s)
      0:       return act8;
      1:       return act2;
      default: return actl;
    endcase
  endfunction

  function automatic logic dn_of(input int s);
    case (s)
      0:       return dn8;
      1:       return dn2;
      default: return dnl;
    endcase
  endfunction

  task automatic drive(input int s, input logic v, input logic [7:0] b);
    case (s)
      0:       begin dv8 = v; b8 = b; end
      1:       begin dv2 = v; b2 = b; end
      default: begin dvl = v; bl = b; end
    endcase
  endtask

  // Mid-bit samples of a captured frame, returned as {stop, data[7:0], start}.
  function automatic logic [9:0] decode(input int base, input int cpb);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = cap[base + i * cpb + cpb / 2];
    return r;
  endfunction

  // Sends one byte and checks every cycle of its frame plus Active/Done timing.
  task automatic frame_check(input vec_t v);
    logic       smp [0:81];
    int         n, act_cnt, done_cnt, done_at;
    logic [7:0] got_bits, exp_bits;
    n = 10 * v.cpb;
    act_cnt = 0; done_cnt = 0; done_at = -1;
    drive(v.inst, 1'b1, v.dat);
    @(negedge clk);
    drive(v.inst, 1'b0, 8'h00);
    check($sformatf("v%02h_c%0d_pre_start", v.dat, v.cpb), ser_of(v.inst), 1);
    for (int j = 0; j < n + 2; j++) begin
      @(negedge clk);
      smp[j] = ser_of(v.inst);
      if (act_of(v.inst)) act_cnt++;
      if (dn_of(v.inst)) begin done_cnt++; done_at = j; end
    end
    for (int i = 0; i < 10; i++) begin
      got_bits = '0;
      exp_bits = '0;
      for (int c = 0; c < v.cpb; c++) begin
        got_bits[c] = smp[i * v.cpb + c];
        exp_bits[c] = v.frame[i];
      end
      check($sformatf("v%02h_c%0d_bit%0d", v.dat, v.cpb, i), got_bits, exp_bits);
    end
    check($sformatf("v%02h_c%0d_active_len", v.dat, v.cpb), act_cnt, n);
    check($sformatf("v%02h_c%0d_done_count", v.dat, v.cpb), done_cnt, 1);
    check($sformatf("v%02h_c%0d_done_cycle", v.dat, v.cpb), done_at, n);
  endtask

`ifdef TX_FIFO_EN
  // 20 consecutive offers into a 16-deep FIFO: 17 accepted, 3 dropped.
  task automatic burst();
    int nbad;
    for (int t = 0; t < 1406; t++) begin
      cap[t]     = ser8;
      cap_rdy[t] = rdy8;
      if (t < 20) drive(0, 1'b1, 8'(t));
      else        drive(0, 1'b0, 8'h00);
      @(negedge clk);
    end
    nbad = 0;
    for (int t = 0; t < 20; t++) if (cap_rdy[t] !== (t <= 16)) nbad++;
    check("burst_ready_profile_errs", nbad, 0);
    check("burst_ready_before_17th", cap_rdy[16], 1);
    check("burst_ready_after_17th", cap_rdy[17], 0);
    for (int f = 0; f < 17; f++)
      check($sformatf("burst_frame%0d", f), decode(2 + 82 * f, 8), {1'b1, 8'(f), 1'b0});
    nbad = 0;
    for (int t = 1396; t < 1406; t++) if (cap[t] !== 1'b1) nbad++;
    check("burst_idle_after_last", nbad, 0);
  endtask
`else
  // Holding-register timing: second byte waits for the pop, third is dropped.
  task automatic nofifo();
    int nbad;
    drive(0, 1'b1, 8'h3C);
    @(negedge clk);
    check("nf_ready_after_accept", rdy8, 0);
    drive(0, 1'b0, 8'h00);
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      cap[j]     = ser8;
      cap_rdy[j] = rdy8;
      if (j == 0)      drive(0, 1'b1, 8'hC3);
      else if (j == 1) drive(0, 1'b1, 8'h77);
      else if (j == 9) drive(0, 1'b0, 8'h00);
    end
    check("nf_ready_at_k1", cap_rdy[0], 1);
    check("nf_ready_at_k2", cap_rdy[1], 0);
    nbad = 0;
    for (int j = 1; j < 82; j++) if (cap_rdy[j] !== 1'b0) nbad++;
    check("nf_ready_low_span_errs", nbad, 0);
    check("nf_ready_at_k83", cap_rdy[82], 1);
    check("nf_frame0", decode(0, 8), {1'b1, 8'h3C, 1'b0});
    check("nf_frame1", decode(82, 8), {1'b1, 8'hC3, 1'b0});
    nbad = 0;
    for (int j = 162; j < 200; j++) if (cap[j] !== 1'b1) nbad++;
    check("nf_third_dropped_idle", nbad, 0);
  endtask
`endif

  // Reset asserted between edges during data bit 3 of 0xA5 with bytes queued.
  task automatic mid_reset();
    int nbad;
    drive(0, 1'b1, 8'hA5); @(negedge clk);
    drive(0, 1'b1, 8'h11); @(negedge clk);
    drive(0, 1'b1, 8'h22); @(negedge clk);
    drive(0, 1'b1, 8'h33); @(negedge clk);
    drive(0, 1'b0, 8'h00);
    repeat (33) @(negedge clk);
    check("mr_bit3_serial", ser8, 0);
    check("mr_active_before", act8, 1);
    #2 rst = 1'b1;
    #1;
    check("mr_serial_async", ser8, 1);
    check("mr_ready_in_reset", rdy8, 1);
    check("mr_active_in_reset", act8, 0);
    nbad = 0;
    repeat (2) begin
      @(negedge clk);
      if (dn8 !== 1'b0) nbad++;
    end
    rst = 1'b0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (ser8 !== 1'b1 || act8 !== 1'b0 || dn8 !== 1'b0) nbad++;
    end
    check("mr_idle_after_release_errs", nbad, 0);
    check("mr_ready_after_release", rdy8, 1);
  endtask

  // Behavioural 8N1 receiver sampling at mid-bit.
  task automatic rx_model(input int s, input int cpb, input int nfr);
    for (int f = 0; f < nfr; f++) begin
      int         w;
      logic [7:0] b;
      w = 0;
      while (ser_of(s) !== 1'b0 && w < 40000) begin @(negedge clk); w++; end
      if (w >= 40000) begin fail_wait("rx_start_edge"); break; end
      repeat (cpb / 2) @(negedge clk);
      check($sformatf("rx%0d_start_level", f), ser_of(s), 0);
      for (int i = 0; i < 8; i++) begin
        repeat (cpb) @(negedge clk);
        b[i] = ser_of(s);
      end
      repeat (cpb) @(negedge clk);
      check($sformatf("rx%0d_stop_level", f), ser_of(s), 1);
      rx_got[rx_cnt] = b;
      rx_cnt++;
    end
  endtask

  task automatic loopback();
    logic [7:0] tx_b [4];
    tx_b   = '{8'h00, 8'hFF, 8'h55, 8'h80};
    rx_cnt = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int w;
          w = 0;
          while (rdyl !== 1'b1 && w < 30000) begin @(negedge clk); w++; end
          if (w >= 30000) begin fail_wait("lb_ready"); break; end
          drive(2, 1'b1, tx_b[i]);
          @(negedge clk);
          drive(2, 1'b0, 8'h00);
        end
      end
      rx_model(2, 1085, 4);
    join
    check("lb_frame_count", rx_cnt, 4);
    for (int i = 0; i < 4; i++) check($sformatf("lb_byte%0d", i), rx_got[i], tx_b[i]);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dv8 = 1'b0; dv2 = 1'b0; dvl = 1'b0;
    b8  = 8'h00; b2 = 8'h00; bl = 8'h00;
    for (int i = 0; i < 4; i++) rx_got[i] = 8'h00;
    vecs[0] = '{0, 8, 8'hA5, 10'b1_10100101_0};
    vecs[1] = '{0, 8, 8'h00, 10'b1_00000000_0};
    vecs[2] = '{0, 8, 8'hFF, 10'b1_11111111_0};
    vecs[3] = '{0, 8, 8'h3C, 10'b1_00111100_0};
    vecs[4] = '{1, 2, 8'h01, 10'b1_00000001_0};

    repeat (3) @(negedge clk);
    check("rst_serial", ser8, 1);
    check("rst_active", act8, 0);
    check("rst_done", dn8, 0);
    check("rst_ready", rdy8, 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_serial", ser8, 1);
    check("idle_ready", rdy8, 1);

    for (int v = 0; v < 5; v++) frame_check(vecs[v]);

`ifdef TX_FIFO_EN
    burst();
`else
    nofifo();
`endif
    mid_reset();
    loopback();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises bytes onto a single line in 8N1 format (start bit, 8 data bits LSB first, stop bit) at CLKS_PER_BIT clocks per bit. It is the transmit counterpart of the block's UART receiver and uses the same bit timing and state encoding. An optional byte FIFO lets a producer queue bytes while a frame is being sent.

## Interface
- CLKS_PER_BIT, 1085: clocks per serial bit; must be ≥ 2.
- FIFO_DEPTH, 16: byte FIFO depth; must be a power of 2. Used only with TX_FIFO_EN.
- i_Clock  input  1  the single clock; all logic is on its rising edge.
- i_Reset  input  1  reset; asynchronous, active-high.
- i_Tx_DV  input  1  byte-valid strobe; a byte is accepted on an edge where i_Tx_DV && o_Tx_Ready.
- i_Tx_Byte  input  8  byte to send; sampled when accepted.
- o_Tx_Ready  output  1  space available; equals !full of the FIFO or holding register.
- o_Tx_Serial  output  1  serial line; registered; idles high.
- o_Tx_Active  output  1  high in START, DATA and STOP.
- o_Tx_Done  output  1  one-cycle pulse when a stop bit completes.

## Operation
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, FIFO empty, state IDLE, counters 0.
- States use 3-bit encoding: IDLE=000, START=001, DATA=010, STOP=011, CLEANUP=100. Any other value goes to IDLE.
- IDLE: serial=1. If the buffer is non-empty, pop one byte into the shift register, drive serial=0, clear the clock count, and go to START.
- START: count 0..CLKS_PER_BIT-1. On the last count, drive bit 0, set bit index to 0, and go to DATA.
- DATA: hold each bit for CLKS_PER_BIT cycles. At the end of bit 7, drive serial=1 and go to STOP. Otherwise increment the index and drive the next bit.
- STOP: hold 1 for CLKS_PER_BIT cycles. On the last count, pulse o_Tx_Done and go to CLEANUP.
- CLEANUP: one cycle with serial=1, then go to IDLE.
- The clock counter is $clog2(CLKS_PER_BIT) bits wide and never exceeds CLKS_PER_BIT-1. The bit index is 3 bits.
- Accept while full: the byte is dropped and state is unchanged.
- Simultaneous push and pop: count is unchanged and the data order is preserved. Ready is computed from the pre-edge count, so there is never a push into a full buffer.
- i_Tx_Byte changing mid-frame has no effect; only the shift register drives the line.
- Reset mid-frame: serial goes to 1 immediately (asynchronous), the FIFO is flushed, there is no Done pulse, and the partial frame is abandoned.

## Timing
- A byte accepted at edge k drives the start bit from edge k+1, provided the FSM is idle.
- Each bit (start, data, stop) lasts exactly CLKS_PER_BIT cycles.
- o_Tx_Done is high for the single cycle after edge k+1+10·CLKS_PER_BIT.
- With back-to-back buffered bytes, the frame period is 10·CLKS_PER_BIT+2 cycles: the effective stop bit is CLKS_PER_BIT+2 long (CLEANUP + IDLE).
- o_Tx_Ready is combinational from registered state; there are no other combinational paths from inputs to outputs.

## Configuration
- TX_FIFO_EN defined:
  - Bytes are buffered in a FIFO_DEPTH-entry FIFO.
  - o_Tx_Ready = (count != FIFO_DEPTH).
  - Up to FIFO_DEPTH+1 bytes can be outstanding, including the one in the shift register.
- TX_FIFO_EN undefined:
  - A single holding register with a valid flag replaces the FIFO; FIFO_DEPTH is ignored.
  - o_Tx_Ready = !valid.
  - Latency and frame timing are identical to the FIFO build.

## Structure
- Shared package uart_pkg holds:
  - the state encodings;
  - the default CLKS_PER_BIT;
  - the frame constants: 8 data bits, 1 stop bit, idle level 1.
- Sub-module uart_tx_fifo: synchronous FIFO with asynchronous active-high reset, ptr+1-bit pointers, and full/empty flags. It is instantiated only under TX_FIFO_EN.

## Test plan
All scenarios use CLKS_PER_BIT=8 unless noted.
- **Single byte:** reset, then accept 0xA5 at edge k.
  - Serial carries 0 | 1,0,1,0,0,1,0,1 | 1, each bit 8 cycles, starting at edge k+1.
  - o_Tx_Done pulses once, in the cycle after edge k+81.
  - o_Tx_Active is high for exactly 80 cycles.
- **Burst (TX_FIFO_EN, FIFO_DEPTH=16):** hold i_Tx_DV with bytes 0x00..0x13.
  - Exactly 17 bytes (0x00..0x10) are accepted; 0x11..0x13 are dropped.
  - o_Tx_Ready falls after the 17th accept.
  - Frames are spaced 82 cycles apart and carry the accepted bytes in order.
- **Loopback (CLKS_PER_BIT=1085):** send 0x00, 0xFF, 0x55, 0x80 into the UART receiver.
  - The receiver reports the same four bytes in order, each with one DV pulse.
- **Reset mid-frame:** assert i_Reset during DATA bit 3 with 3 bytes queued.
  - o_Tx_Serial=1 without waiting for an edge.
  - o_Tx_Ready=1, o_Tx_Active=0, no Done pulse.
  - After release, the line stays idle.
- **No-FIFO build (TX_FIFO_EN undefined):**
  - Accept 0x3C at edge k. Ready is low for one cycle, then high at edge k+1.
  - 0xC3 is accepted at k+2; Ready stays low until edge k+83.
  - A third byte presented while Ready is low is dropped.
  - The line carries 0x3C, then 0xC3.
- **Minimum rate (CLKS_PER_BIT=2):** send 0x01.
  - Every bit lasts 2 cycles and the frame lasts 20 cycles.
  - The counter never exceeds 1.
